// File: rtl/complex_sync_fifo_pkg.sv
// ============================================================================
// complex_sync_fifo_pkg : shared widths, I/Q field positions and FIFO defaults
// Revision: 1.0
// ============================================================================
`default_nettype none

package complex_sync_fifo_pkg;

   localparam int CPLX_DATA_WIDTH = 32;
   localparam int CPLX_I_MSB      = 31;
   localparam int CPLX_I_LSB      = 16;
   localparam int CPLX_Q_MSB      = 15;
   localparam int CPLX_Q_LSB      = 0;
   localparam int FIFO_ADDR_WIDTH = 10;

   typedef struct packed {
      logic [CPLX_I_MSB-CPLX_I_LSB:0] i;
      logic [CPLX_Q_MSB-CPLX_Q_LSB:0] q;
   } cplx_t;

   function automatic logic [CPLX_DATA_WIDTH-1:0] cplx_pack(
      input logic [15:0] i_val,
      input logic [15:0] q_val
   );
      cplx_t s;
      s.i = i_val;
      s.q = q_val;
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/complex_sync_fifo_if.sv
// ============================================================================
// complex_sync_fifo_if : push/pull handshake and status bundle for the FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

interface complex_sync_fifo_if
   import complex_sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = CPLX_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) ();

   logic                  push;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  pull;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  valid;
   logic                  full;
   logic                  empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output push, wdata, pull,
      input  rdata, valid, full, empty, count, overflow, underflow
   );

   modport slave (
      input  push, wdata, pull,
      output rdata, valid, full, empty, count, overflow, underflow
   );

endinterface

`default_nettype wire

// File: rtl/complex_sync_fifo_ram.sv
// ============================================================================
// complex_sync_fifo_ram : simple dual-port RAM, one write port, one registered
//                         read port, single clock, no reset (EBR inferable)
// Revision: 1.0
// ============================================================================
`default_nettype none

module complex_sync_fifo_ram
   import complex_sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = CPLX_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  wire logic                  clk,
   input  wire logic                  we,
   input  wire logic [ADDR_WIDTH-1:0] waddr,
   input  wire logic [DATA_WIDTH-1:0] wdata,
   input  wire logic                  re,
   input  wire logic [ADDR_WIDTH-1:0] raddr,
   output      logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/complex_sync_fifo.sv
// ============================================================================
// complex_sync_fifo : single-clock FIFO for packed I/Q samples with registered
//                     flags, occupancy count and sticky over/underflow errors
// Revision: 1.0
// ============================================================================
`default_nettype none

module complex_sync_fifo
   import complex_sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = CPLX_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input wire logic           clk,
   input wire logic           rst_n,
   complex_sync_fifo_if.slave bus
);

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   wr_ptr_nxt;
   logic [ADDR_WIDTH:0]   rd_ptr_nxt;
   logic                  full_q;
   logic                  empty_q;
   logic                  valid_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  has_data;
   logic                  push_ok;
   logic                  pull_ok;
   logic [DATA_WIDTH-1:0] ram_q;

   assign push_ok    = bus.push && !full_q;
   assign pull_ok    = bus.pull && !empty_q;
   assign wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, push_ok};
   assign rd_ptr_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, pull_ok};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         has_data    <= 1'b0;
      end else begin
         wr_ptr      <= wr_ptr_nxt;
         rd_ptr      <= rd_ptr_nxt;
         // Wrap bit distinguishes full from empty when the addresses coincide.
         full_q      <= (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                        (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
         empty_q     <= (wr_ptr_nxt == rd_ptr_nxt);
         valid_q     <= pull_ok;
         overflow_q  <= overflow_q  | (bus.push && full_q);
         underflow_q <= underflow_q | (bus.pull && empty_q);
         has_data    <= has_data | pull_ok;
      end
   end

   // Read and write addresses only coincide when full or empty, and in those
   // states one of the two ports is idle, so no read-during-write case exists.
   complex_sync_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (bus.wdata),
      .re    (pull_ok),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (ram_q)
   );

   // RAM output is not resettable; present zero until the first read after reset.
   assign bus.rdata     = has_data ? ram_q : '0;
   assign bus.valid     = valid_q;
   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.count     = wr_ptr - rd_ptr;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_complex_sync_fifo.sv
// ============================================================================
// tb_complex_sync_fifo : directed + random checks of complex_sync_fifo against
//                        a queue-based reference model (DEPTH = 4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_complex_sync_fifo;
   import complex_sync_fifo_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 2;
   localparam int DEPTH = 2**AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_data;
   logic          exp_valid;
   logic          exp_ovf;
   logic          exp_unf;

   always #5 clk = ~clk;

   complex_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   complex_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".data"},  bus.rdata,           exp_data);
      check({tag, ".valid"}, {31'd0, bus.valid},  {31'd0, exp_valid});
      check({tag, ".full"},  {31'd0, bus.full},   {31'd0, mq.size() == DEPTH});
      check({tag, ".empty"}, {31'd0, bus.empty},  {31'd0, mq.size() == 0});
      check({tag, ".count"}, {29'd0, bus.count},  DW'(mq.size()));
      check({tag, ".ovf"},   {31'd0, bus.overflow},  {31'd0, exp_ovf});
      check({tag, ".unf"},   {31'd0, bus.underflow}, {31'd0, exp_unf});
   endtask

   function automatic void model_reset();
      mq.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
   endfunction

   // Called #1 after a rising edge: drive, predict, clock once, compare.
   task automatic cycle(input string tag, input logic p, input logic [DW-1:0] d, input logic q);
      logic was_full;
      logic was_empty;
      bus.push  = p;
      bus.wdata = d;
      bus.pull  = q;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      exp_valid = 1'b0;
      if (q && !was_empty) begin
         exp_data  = mq.pop_front();
         exp_valid = 1'b1;
      end
      if (p && !was_full) mq.push_back(d);
      if (p && was_full)  exp_ovf = 1'b1;
      if (q && was_empty) exp_unf = 1'b1;
      @(posedge clk);
      #1;
      bus.push = 1'b0;
      bus.pull = 1'b0;
      check_all(tag);
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return cplx_pack(16'($urandom), 16'($urandom));
   endfunction

   initial begin
      bus.push  = 1'b0;
      bus.pull  = 1'b0;
      bus.wdata = '0;
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all("reset");
      cycle("reset_idle", 1'b0, '0, 1'b0);

      // Fill with the directed I/Q words.
      for (int k = 0; k < DEPTH; k++)
         cycle("fill", 1'b1, cplx_pack(16'(k + 1), 16'(k + 2)), 1'b0);
      cycle("push_full", 1'b1, 32'hDEAD_BEEF, 1'b0);

      for (int k = 0; k < DEPTH; k++) begin
         cycle("drain", 1'b0, '0, 1'b1);
         cycle("drain_gap", 1'b0, '0, 1'b0);
      end
      cycle("pull_empty", 1'b0, '0, 1'b1);
      cycle("pull_empty_idle", 1'b0, '0, 1'b0);

      // Steady push+pull at count=2 across several pointer wraps.
      cycle("pre2a", 1'b1, rnd_word(), 1'b0);
      cycle("pre2b", 1'b1, rnd_word(), 1'b0);
      for (int k = 0; k < 20; k++)
         cycle("stream2", 1'b1, rnd_word(), 1'b1);

      while (mq.size() < DEPTH) cycle("refill", 1'b1, rnd_word(), 1'b0);
      cycle("full_both", 1'b1, rnd_word(), 1'b1);
      cycle("after_full_both", 1'b0, '0, 1'b0);
      while (mq.size() > 0) cycle("empty_out", 1'b0, '0, 1'b1);
      cycle("empty_both", 1'b1, rnd_word(), 1'b1);
      cycle("after_empty_both", 1'b0, '0, 1'b0);

      // Async reset with three words stored, checked before any clock edge.
      while (mq.size() < 3) cycle("to3", 1'b1, rnd_word(), 1'b0);
      cycle("at3_pull", 1'b0, '0, 1'b1);
      cycle("at3_push", 1'b1, rnd_word(), 1'b0);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all("reset_release");

      // Random traffic.
      for (int k = 0; k < 300; k++)
         cycle("random", 1'($urandom_range(0, 1)), rnd_word(), 1'($urandom_range(0, 1)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
